// File: rtl/mix_sequencer_pkg.sv
// Shared constants, lane types and FSM state encoding for the 8-lane mix sequencer.
package mix_sequencer_pkg;

   localparam int unsigned LANES      = 8;
   localparam int unsigned LANE_W     = 32;
   localparam int unsigned NUM_STAGES = 7;
   localparam int unsigned DATA_W     = LANES * LANE_W;

   // Lane i occupies bits [32i+31:32i] of the flat 256-bit bus.
   typedef logic [LANES-1:0][LANE_W-1:0] lanes_t;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [LANE_W-1:0] MIX_M [LANES] = '{32'd2, 32'd3, 32'd5, 32'd7,
                                                   32'd11, 32'd13, 32'd17, 32'd19};
   localparam logic [LANE_W-1:0] MIX_C [LANES] = '{32'd3, 32'd5, 32'd7, 32'd11,
                                                   32'd13, 32'd17, 32'd19, 32'd23};

endpackage

// File: rtl/mix_stage.sv
// Combinational evaluation of one mix stage across all eight lanes.
module mix_stage
   import mix_sequencer_pkg::*;
(
   input  logic [DATA_W-1:0] lanes,
   input  logic [2:0]        stage,
   output logic [DATA_W-1:0] next_lanes_c
);

   lanes_t     o;
   logic [2:0] k;

   // In-place update in lane order, so lane k sees new values below it and old values above it.
   always_comb begin
      o = lanes;
      k = '0;
      for (int i = 0; i < int'(LANES); i++) begin
         k = 3'(i);
         unique case (stage)
            3'd0: o[k] = o[k] + LANE_W'(i);
            3'd1: o[k] = o[k] + o[k - 3'd1];
            3'd2: o[k] = o[k] + o[k + 3'd1] - o[k + 3'd5];
            3'd3: o[k] = o[k] ^ (o[k + 3'd3] << 16);
            3'd4: o[k] = o[k] - (o[k + 3'd2] >> 17) + (o[k + 3'd4] >> 12);
            3'd5: o[k] = o[k] + o[k - 3'd1] - o[k - 3'd2];
            3'd6: o[k] = o[k] * MIX_M[k] + MIX_C[k];
            default: o[k] = o[k];
         endcase
      end
   end

   assign next_lanes_c = o;

endmodule

// File: rtl/mix_sequencer.sv
// Iterative 8x32-bit mix sequencer: accept a seed, run ROUNDS x 7 stages, present the result.
// Define MIX_SEQUENCER_STATS_EN to add the jobs_done / busy_cycles counter outputs.
module mix_sequencer
   import mix_sequencer_pkg::*;
#(
   parameter int unsigned            ROUNDS     = 2,
   parameter logic [NUM_STAGES-1:0]  STAGE_MASK = 7'h7F
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   input  logic              abort,
   output logic              busy,
   output logic [2:0]        stage_idx,
   output logic [3:0]        round_idx
`ifdef MIX_SEQUENCER_STATS_EN
   ,
   output logic [31:0]       jobs_done,
   output logic [31:0]       busy_cycles
`endif
);

   // Padded to 8 bits so any 3-bit stage index selects in range.
   localparam logic [7:0] MASK_EXT = {1'b0, STAGE_MASK};

   state_t            state;
   logic [DATA_W-1:0] lanes;
   logic [DATA_W-1:0] mixed_c;

   mix_stage u_stage (
      .lanes        (lanes),
      .stage        (stage_idx),
      .next_lanes_c (mixed_c)
   );

   assign out_data = lanes;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         lanes     <= '0;
         stage_idx <= '0;
         round_idx <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  lanes     <= in_data;
                  stage_idx <= '0;
                  round_idx <= '0;
                  state     <= RUN;
                  busy      <= 1'b1;
                  in_ready  <= 1'b0;
               end
            end
            RUN: begin
               if (abort) begin
                  state     <= IDLE;
                  stage_idx <= '0;
                  round_idx <= '0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
               end else begin
                  if (MASK_EXT[stage_idx]) lanes <= mixed_c;
                  if (stage_idx == 3'(NUM_STAGES - 1)) begin
                     stage_idx <= '0;
                     if (round_idx == 4'(ROUNDS - 1)) begin
                        round_idx <= '0;
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                     end else begin
                        round_idx <= round_idx + 4'd1;
                     end
                  end else begin
                     stage_idx <= stage_idx + 3'd1;
                  end
               end
            end
            DONE: begin
               // Abort and handshake both release the result; in_ready rises one cycle later.
               if (abort || out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               busy      <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

`ifdef MIX_SEQUENCER_STATS_EN
   // Aborted results never count as delivered jobs.
   always_ff @(posedge clk) begin
      if (rst) begin
         jobs_done   <= '0;
         busy_cycles <= '0;
      end else begin
         if (state == DONE && out_ready && !abort) jobs_done <= jobs_done + 32'd1;
         if (state == RUN) busy_cycles <= busy_cycles + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mix_sequencer.sv
// Directed bench for mix_sequencer: three ROUNDS=1 masked instances plus one default instance.
module tb_mix_sequencer;
   import mix_sequencer_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   // Shared stimulus for the three single-round masked instances.
   logic       s_in_valid, s_out_ready;
   lanes_t     s_in_data;
   logic [2:0] s_in_ready, s_out_valid, s_busy;
   lanes_t     s_out_data [3];
   logic [2:0] s_stage [3];
   logic [3:0] s_round [3];

   // Default-parameter instance.
   logic       d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_abort, d_busy;
   lanes_t     d_in_data, d_out_data;
   logic [2:0] d_stage;
   logic [3:0] d_round;

`ifdef MIX_SEQUENCER_STATS_EN
   logic [31:0] s_jobs [3];
   logic [31:0] s_bcyc [3];
   logic [31:0] d_jobs, d_bcyc;
`endif

   int n_cmp = 0;
   int n_err = 0;

   mix_sequencer #(.ROUNDS(1), .STAGE_MASK(7'h03)) u_a (
      .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready[0]), .in_data(s_in_data),
      .out_valid(s_out_valid[0]), .out_ready(s_out_ready), .out_data(s_out_data[0]), .abort(1'b0),
      .busy(s_busy[0]), .stage_idx(s_stage[0]), .round_idx(s_round[0])
`ifdef MIX_SEQUENCER_STATS_EN
      , .jobs_done(s_jobs[0]), .busy_cycles(s_bcyc[0])
`endif
   );

   mix_sequencer #(.ROUNDS(1), .STAGE_MASK(7'h40)) u_b (
      .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready[1]), .in_data(s_in_data),
      .out_valid(s_out_valid[1]), .out_ready(s_out_ready), .out_data(s_out_data[1]), .abort(1'b0),
      .busy(s_busy[1]), .stage_idx(s_stage[1]), .round_idx(s_round[1])
`ifdef MIX_SEQUENCER_STATS_EN
      , .jobs_done(s_jobs[1]), .busy_cycles(s_bcyc[1])
`endif
   );

   mix_sequencer #(.ROUNDS(1), .STAGE_MASK(7'h08)) u_c (
      .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready[2]), .in_data(s_in_data),
      .out_valid(s_out_valid[2]), .out_ready(s_out_ready), .out_data(s_out_data[2]), .abort(1'b0),
      .busy(s_busy[2]), .stage_idx(s_stage[2]), .round_idx(s_round[2])
`ifdef MIX_SEQUENCER_STATS_EN
      , .jobs_done(s_jobs[2]), .busy_cycles(s_bcyc[2])
`endif
   );

   mix_sequencer u_d (
      .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready), .in_data(d_in_data),
      .out_valid(d_out_valid), .out_ready(d_out_ready), .out_data(d_out_data), .abort(d_abort),
      .busy(d_busy), .stage_idx(d_stage), .round_idx(d_round)
`ifdef MIX_SEQUENCER_STATS_EN
      , .jobs_done(d_jobs), .busy_cycles(d_bcyc)
`endif
   );

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model written straight from the stage definitions.
   function automatic lanes_t ref_mix(input lanes_t seed, input int rounds, input logic [6:0] mask);
      logic [31:0] v  [8];
      logic [31:0] mm [8];
      logic [31:0] cc [8];
      logic [2:0]  k;
      mm = '{32'd2, 32'd3, 32'd5, 32'd7, 32'd11, 32'd13, 32'd17, 32'd19};
      cc = '{32'd3, 32'd5, 32'd7, 32'd11, 32'd13, 32'd17, 32'd19, 32'd23};
      for (int i = 0; i < 8; i++) begin
         k = 3'(i);
         v[k] = seed[k];
      end
      for (int r = 0; r < rounds; r++) begin
         for (int s = 0; s < 7; s++) begin
            if (mask[3'(s)]) begin
               for (int i = 0; i < 8; i++) begin
                  k = 3'(i);
                  case (s)
                     0: v[k] = v[k] + 32'(i);
                     1: v[k] = v[k] + v[3'(i + 7)];
                     2: v[k] = v[k] + v[3'(i + 1)] - v[3'(i + 5)];
                     3: v[k] = v[k] ^ {v[3'(i + 3)][15:0], 16'h0000};
                     4: v[k] = v[k] - {17'd0, v[3'(i + 2)][31:17]} + {12'd0, v[3'(i + 4)][31:12]};
                     5: v[k] = v[k] + v[3'(i + 7)] - v[3'(i + 6)];
                     default: v[k] = v[k] * mm[k] + cc[k];
                  endcase
               end
            end
         end
      end
      for (int i = 0; i < 8; i++) begin
         k = 3'(i);
         ref_mix[k] = v[k];
      end
   endfunction

   function automatic lanes_t rand_seed();
      lanes_t x;
      for (int i = 0; i < 8; i++) x[3'(i)] = $urandom;
      return x;
   endfunction

   task automatic small_job(input lanes_t seed, output int lat);
      @(negedge clk);
      s_in_data  = seed;
      s_in_valid = 1'b1;
      @(negedge clk);
      s_in_valid = 1'b0;
      lat = 0;
      while (s_out_valid[0] !== 1'b1 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic small_release();
      @(negedge clk);
      s_out_ready = 1'b1;
      @(negedge clk);
      s_out_ready = 1'b0;
      chk("s_release", 256'({s_out_valid, s_in_ready}), 256'({3'b000, 3'b111}));
   endtask

   task automatic d_start(input lanes_t seed, input logic with_abort);
      @(negedge clk);
      d_in_data  = seed;
      d_in_valid = 1'b1;
      d_abort    = with_abort;
      @(negedge clk);
      d_in_valid = 1'b0;
      d_abort    = 1'b0;
   endtask

   task automatic d_wait(output int lat, output logic ir_seen);
      lat     = 0;
      ir_seen = d_in_ready;
      while (d_out_valid !== 1'b1 && lat < 100) begin
         @(negedge clk);
         lat++;
         ir_seen |= d_in_ready;
      end
   endtask

   task automatic d_release();
      @(negedge clk);
      d_out_ready = 1'b1;
      @(negedge clk);
      d_out_ready = 1'b0;
      chk("d_release", 256'({d_out_valid, d_in_ready}), 256'(2'b01));
   endtask

   initial begin
      lanes_t seed, exp;
      int     lat;
      logic   ir_seen, seen;

      rst = 1'b1;
      s_in_valid = 1'b0; s_out_ready = 1'b0; s_in_data = '0;
      d_in_valid = 1'b0; d_out_ready = 1'b0; d_abort = 1'b0; d_in_data = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      chk("rst_ctl", 256'({d_in_ready, d_out_valid, d_busy, d_stage, d_round}), 256'({1'b1, 1'b0, 1'b0, 3'd0, 4'd0}));
      chk("rst_data", d_out_data, '0);
      chk("rst_small", 256'({s_in_ready, s_out_valid, s_busy}), 256'({3'b111, 3'b000, 3'b000}));

      // Mask 0x03, zero seed.
      small_job('0, lat);
      chk("m03_lat", 256'(lat), 256'(7));
      exp = '0;
      exp[0] = 32'd7;  exp[1] = 32'd8;  exp[2] = 32'd10; exp[3] = 32'd13;
      exp[4] = 32'd17; exp[5] = 32'd22; exp[6] = 32'd28; exp[7] = 32'd35;
      chk("m03_data", s_out_data[0], exp);
      small_release();

      // Mask 0x40, every lane 1.
      seed = '0;
      for (int i = 0; i < 8; i++) seed[3'(i)] = 32'd1;
      small_job(seed, lat);
      exp[0] = 32'd5;  exp[1] = 32'd8;  exp[2] = 32'd12; exp[3] = 32'd18;
      exp[4] = 32'd24; exp[5] = 32'd30; exp[6] = 32'd36; exp[7] = 32'd42;
      chk("m40_data", s_out_data[1], exp);
      small_release();

      // Mask 0x08, lane3 = 1; lane5 loses the bit shifted past 32.
      seed = '0;
      seed[3] = 32'd1;
      small_job(seed, lat);
      exp = '0;
      exp[0] = 32'h0001_0000;
      exp[3] = 32'd1;
      chk("m08_data", s_out_data[2], exp);
      small_release();

      // Default instance, random seed, sink stalled 5 cycles.
      seed = rand_seed();
      exp  = ref_mix(seed, 2, 7'h7F);
      d_start(seed, 1'b0);
      chk("run_ctl", 256'({d_busy, d_in_ready, d_stage, d_round}), 256'({1'b1, 1'b0, 3'd0, 4'd0}));
      d_wait(lat, ir_seen);
      chk("def_lat", 256'(lat), 256'(14));
      chk("def_inready_run", 256'(ir_seen), 256'(0));
      for (int c = 0; c < 5; c++) begin
         chk("stall_data", d_out_data, exp);
         chk("stall_ctl", 256'({d_out_valid, d_in_ready, d_busy}), 256'(3'b100));
         @(negedge clk);
      end
      d_release();

      // Second random job through the default instance.
      seed = rand_seed();
      exp  = ref_mix(seed, 2, 7'h7F);
      d_start(seed, 1'b0);
      d_wait(lat, ir_seen);
      chk("def2_lat", 256'(lat), 256'(14));
      chk("def2_data", d_out_data, exp);
      d_release();

      // Abort at stage 3 of round 1.
      d_start(rand_seed(), 1'b0);
      repeat (10) @(negedge clk);
      chk("abort_pos", 256'({d_stage, d_round}), 256'({3'd3, 4'd1}));
      d_abort = 1'b1;
      @(negedge clk);
      d_abort = 1'b0;
      chk("abort_ctl", 256'({d_out_valid, d_in_ready, d_busy}), 256'(3'b010));
      seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         seen |= d_out_valid;
      end
      chk("abort_noout", 256'(seen), 256'(0));
      seed = rand_seed();
      exp  = ref_mix(seed, 2, 7'h7F);
      d_start(seed, 1'b0);
      d_wait(lat, ir_seen);
      chk("post_abort_data", d_out_data, exp);
      d_release();

      // Reset mid-run, then accept with abort held (abort ignored in IDLE).
      d_start(rand_seed(), 1'b0);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_ctl", 256'({d_out_valid, d_busy, d_in_ready, d_stage, d_round}), 256'({3'b001, 3'd0, 4'd0}));
      chk("mid_rst_data", d_out_data, '0);
      seed = rand_seed();
      exp  = ref_mix(seed, 2, 7'h7F);
      d_start(seed, 1'b1);
      chk("idle_abort_ignored", 256'(d_busy), 256'(1));
      d_wait(lat, ir_seen);
      chk("post_rst_lat", 256'(lat), 256'(14));
      chk("post_rst_data", d_out_data, exp);
      d_release();
`ifdef MIX_SEQUENCER_STATS_EN
      chk("jobs_done", 256'(d_jobs), 256'(1));
      chk("busy_cycles", 256'(d_bcyc), 256'(14));
`endif

      // Abort beats the handshake in DONE.
      d_start(rand_seed(), 1'b0);
      d_wait(lat, ir_seen);
      chk("done_valid", 256'(d_out_valid), 256'(1));
      @(negedge clk);
      d_abort     = 1'b1;
      d_out_ready = 1'b1;
      @(negedge clk);
      d_abort     = 1'b0;
      d_out_ready = 1'b0;
      chk("done_abort_ctl", 256'({d_out_valid, d_in_ready}), 256'(2'b01));
`ifdef MIX_SEQUENCER_STATS_EN
      chk("jobs_after_abort", 256'(d_jobs), 256'(1));
      chk("busy_after_abort", 256'(d_bcyc), 256'(28));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
